// File: rtl/mux.sv
// Two-input mux with registered copies of the output and select, plus select-change tracking.
// Optional registered parity output par_q is built only when MUX_PARITY_EN is defined.
module mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             s_q,
  output logic             sw_pulse,
`ifdef MUX_PARITY_EN
  output logic             par_q,
`endif
  output logic [CNT_W-1:0] sw_cnt
);

  logic sel_change;
  logic cnt_sat;

  // y stays purely combinational so it keeps following the inputs even while reset is held.
  assign y          = s ? b : a;
  assign sel_change = (s != s_q);
  assign cnt_sat    = (sw_cnt == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q      <= '0;
      s_q      <= 1'b0;
      sw_pulse <= 1'b0;
      sw_cnt   <= '0;
    end else begin
      y_q      <= y;
      s_q      <= s;
      sw_pulse <= sel_change;
      // Saturate rather than wrap so a long-running count never reads as small.
      if (sel_change && !cnt_sat) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= ^y;
    end
  end
`endif

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: truth-table vectors plus hand-written sequences for
// latency, counting, saturation, mid-run reset and (with MUX_PARITY_EN) parity.
module tb_mux;

  logic       clk;
  logic       rst_n;
  logic       a, b, s;
  logic       y, y_q, s_q, sw_pulse;
  logic [7:0] sw_cnt;

  logic       sat_y, sat_y_q, sat_s_q, sat_pulse;
  logic [1:0] sat_cnt;

  logic [3:0] a4, b4;
  logic [3:0] y4, y4_q;
  logic       s4_q, pulse4;
  logic [7:0] cnt4;
`ifdef MUX_PARITY_EN
  logic       par_q, sat_par_q, par4_q;
`endif

  int tests_run;
  int tests_failed;

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mux #(.WIDTH(1), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s),
    .y(y), .y_q(y_q), .s_q(s_q), .sw_pulse(sw_pulse),
`ifdef MUX_PARITY_EN
    .par_q(par_q),
`endif
    .sw_cnt(sw_cnt)
  );

  mux #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .s(s),
    .y(sat_y), .y_q(sat_y_q), .s_q(sat_s_q), .sw_pulse(sat_pulse),
`ifdef MUX_PARITY_EN
    .par_q(sat_par_q),
`endif
    .sw_cnt(sat_cnt)
  );

  mux #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .s(s),
    .y(y4), .y_q(y4_q), .s_q(s4_q), .sw_pulse(pulse4),
`ifdef MUX_PARITY_EN
    .par_q(par4_q),
`endif
    .sw_cnt(cnt4)
  );

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic y;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state, with y live during reset
    rst_n = 1'b0; a = 1'b1; b = 1'b0; s = 1'b0; a4 = 4'h0; b4 = 4'h0;
    step();
    step();
    check("rst_y_q",      32'(y_q),      32'd0);
    check("rst_s_q",      32'(s_q),      32'd0);
    check("rst_sw_pulse", 32'(sw_pulse), 32'd0);
    check("rst_sw_cnt",   32'(sw_cnt),   32'd0);
    check("rst_y_live",   32'(y),        32'd1);

    // Truth table, 10 ns apart
    for (int i = 0; i < 8; i++) begin
      a = vecs[i].a; b = vecs[i].b; s = vecs[i].s;
      #1;
      check($sformatf("tt_y[%0d]", i), 32'(y), 32'(vecs[i].y));
      #9;
    end
    step();

    // Width-4 select, both ways
    a4 = 4'b1010; b4 = 4'b0101; s = 1'b0;
    #1 check("w4_y_a", 32'(y4), 32'h0a);
    s = 1'b1;
    #1 check("w4_y_b", 32'(y4), 32'h05);

    // Latency: fresh reset, then a=1 b=0 s=0, then s=1
    rst_n = 1'b0; s = 1'b0;
    step();
    rst_n = 1'b1; a = 1'b1; b = 1'b0; s = 1'b0;
    step();
    check("lat_y_q_a",    32'(y_q),      32'd1);
    check("lat_pulse_0",  32'(sw_pulse), 32'd0);
    s = 1'b1;
    #1 check("lat_y_immed", 32'(y), 32'd0);
    step();
    check("lat_y_q_b",    32'(y_q),      32'd0);
    check("lat_s_q",      32'(s_q),      32'd1);
    check("lat_pulse_1",  32'(sw_pulse), 32'd1);
    check("lat_cnt_1",    32'(sw_cnt),   32'd1);
    step();
    check("lat_pulse_end", 32'(sw_pulse), 32'd0);
    check("lat_cnt_hold",  32'(sw_cnt),   32'd1);

    // Counting: 5 toggles from a clean reset, then hold
    rst_n = 1'b0; s = 1'b0;
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      step();
      pulses += int'(sw_pulse);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(sw_pulse);
    end
    check("cnt_sw_cnt_5", 32'(sw_cnt),  32'd5);
    check("cnt_pulses_5", 32'(pulses),  32'd5);
    check("cnt_sat_at_5", 32'(sat_cnt), 32'd3);

    // Saturation: 6 toggles, CNT_W=2 stops at 3
    rst_n = 1'b0; s = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s = ~s;
      step();
      if (i == 1) check("sat_cnt_2", 32'(sat_cnt), 32'd2);
    end
    check("sat_cnt_3",   32'(sat_cnt),   32'd3);
    check("sat_main_6",  32'(sw_cnt),    32'd6);
    check("sat_pulse",   32'(sat_pulse), 32'd1);

    // Reset mid-run with saturated counter; y still follows inputs
    rst_n = 1'b0; a = 1'b0; b = 1'b1; s = 1'b1;
    #1 check("mid_y_live", 32'(y), 32'd1);
    step();
    check("mid_y_q",      32'(y_q),      32'd0);
    check("mid_s_q",      32'(s_q),      32'd0);
    check("mid_sw_pulse", 32'(sw_pulse), 32'd0);
    check("mid_sw_cnt",   32'(sw_cnt),   32'd0);
    check("mid_sat_cnt",  32'(sat_cnt),  32'd0);
    s = 1'b0;
    #1 check("mid_y_live2", 32'(y), 32'd0);

    // First edge after release with s=1 counts as a switch
    s = 1'b1;
    rst_n = 1'b1;
    step();
    check("rel_pulse", 32'(sw_pulse), 32'd1);
    check("rel_cnt",   32'(sw_cnt),   32'd1);

    // Data changes with select constant do not count
    for (int i = 0; i < 4; i++) begin
      a = i[0]; b = i[1];
      step();
      check($sformatf("data_pulse[%0d]", i), 32'(sw_pulse), 32'd0);
    end
    check("data_cnt_hold", 32'(sw_cnt), 32'd1);
    check("data_y_q",      32'(y_q),    32'd1);

    // Width-4 registered output and parity
    a4 = 4'b0111; b4 = 4'b0000; s = 1'b0;
    step();
    check("w4_y_q", 32'(y4_q), 32'h07);
`ifdef MUX_PARITY_EN
    check("par_0111", 32'(par4_q), 32'd1);
    a4 = 4'b0011;
    step();
    check("par_0011", 32'(par4_q), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
